// File: rtl/nios_keycode_rx_pkg.sv
// nios_keycode_rx_pkg: register map constants for the keycode receive FIFO slave
package nios_keycode_rx_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_COMMAND = 2'd3;
  localparam int ST_EMPTY    = 16;
  localparam int ST_FULL     = 17;
  localparam int ST_OVERFLOW = 18;
  localparam int CMD_FLUSH   = 0;
  localparam int CMD_CLR_OVF = 1;
  localparam int DATA_VALID  = 31;
endpackage

// File: rtl/keycode_sync_fifo.sv
// keycode_sync_fifo: DEPTH x W synchronous FIFO with count, full/empty and flush
module keycode_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic [AW:0]   count_next,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign full       = count == (AW+1)'(DEPTH);
  assign empty      = count == '0;
  assign rdata      = mem[rp];
  assign count_next = flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  // storage is not reset; push is already qualified by flush in the caller
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      count <= count_next;
      if (flush) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (push) wp <= wp + AW'(1);
        if (pop) rp <= rp + AW'(1);
      end
    end
endmodule

// File: rtl/nios_keycode_rx_fifo.sv
// nios_keycode_rx_fifo: Avalon-MM slave delivering front-end keycodes to the CPU via a FIFO
// Optional KEYCODE_RX_TIMESTAMP_EN adds an 8-bit cycle/1024 timestamp per entry (DATA[30:23]).
module nios_keycode_rx_fifo
  import nios_keycode_rx_pkg::*;
#(
  parameter int KW    = 8,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    address,
  input  logic          chipselect,
  input  logic          read_n,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  input  logic [KW-1:0] in_keycode,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          irq
);
  localparam int AW = $clog2(DEPTH);
`ifdef KEYCODE_RX_TIMESTAMP_EN
  localparam int FW = KW + 8;
  logic [9:0]  prescale;
  logic [15:0] tick;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prescale <= '0;
      tick     <= '0;
    end else begin
      prescale <= prescale + 10'd1;
      if (&prescale) tick <= tick + 16'd1;
    end
  logic [FW-1:0] wdata;
  assign wdata = {tick[7:0], in_keycode};
`else
  localparam int FW = KW;
  logic [FW-1:0] wdata;
  assign wdata = in_keycode;
`endif
  logic [FW-1:0] head;
  logic [AW:0]   count, count_next;
  logic          full, empty, overflow, irq_en;
  logic          wr, flush, clr_ovf, push, pop, ovf_next;
  logic [31:0]   data_word, status_word;
  logic          unused_wd;
  assign unused_wd = ^writedata[31:2];
  assign wr       = chipselect && !write_n;
  assign flush    = wr && address == ADDR_COMMAND && writedata[CMD_FLUSH];
  assign clr_ovf  = wr && address == ADDR_COMMAND && writedata[CMD_CLR_OVF];
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = chipselect && !read_n && address == ADDR_DATA && !empty && !flush;
  // a flush discards the concurrent keycode, so that keycode cannot count as an overflow either
  assign ovf_next = (in_valid && !in_ready && !flush) || (overflow && !clr_ovf);
  keycode_sync_fifo #(.W(FW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk), .reset_n(reset_n), .flush(flush), .push(push), .pop(pop),
    .wdata(wdata), .rdata(head), .count(count), .count_next(count_next),
    .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      overflow <= ovf_next;
      if (wr && address == ADDR_CONTROL) irq_en <= writedata[0];
      irq <= irq_en & (count_next != '0 | ovf_next);
    end
  always_comb begin
    data_word             = '0;
    data_word[DATA_VALID] = !empty;
    data_word[KW-1:0]     = empty ? '0 : head[KW-1:0];
`ifdef KEYCODE_RX_TIMESTAMP_EN
    data_word[30:23]      = empty ? '0 : head[FW-1:KW];
`endif
    status_word              = '0;
    status_word[AW:0]        = count;
    status_word[ST_EMPTY]    = empty;
    status_word[ST_FULL]     = full;
    status_word[ST_OVERFLOW] = overflow;
  end
  assign readdata = address == ADDR_DATA    ? data_word :
                    address == ADDR_STATUS  ? status_word :
                    address == ADDR_CONTROL ? {31'd0, irq_en} : '0;
endmodule

// File: tb/tb_nios_keycode_rx_fifo.sv
// tb_nios_keycode_rx_fifo: directed self-checking bench for nios_keycode_rx_fifo (KW=8, DEPTH=8)
module tb_nios_keycode_rx_fifo;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0, read_n = 1'b1, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  in_keycode = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, irq;
  int          checks = 0, errors = 0;

  nios_keycode_rx_fifo #(.KW(8), .DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_keycode(in_keycode), .in_valid(in_valid), .in_ready(in_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    #1 check(tag, readdata, exp);
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] k);
    @(negedge clk);
    in_valid = 1'b1; in_keycode = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_irq", irq, 0);
    check("rst_ready", in_ready, 1);
    rd(1, 32'h0001_0000, "rst_status");
    rd(0, 32'h0, "rst_data");

    push(8'h1C); push(8'h32); push(8'h23);
    rd(1, 32'h0000_0003, "status3");
    rd(0, 32'h8000_001C, "pop1");
    rd(0, 32'h8000_0032, "pop2");
    rd(0, 32'h8000_0023, "pop3");
    rd(0, 32'h0, "pop_empty");
    rd(1, 32'h0001_0000, "status_after_empty_read");

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_keycode = 8'h40 + 8'(i);
      #1 check("ready_fill", in_ready, i < 8);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rd(1, 32'h0006_0008, "status_full_ovf");
    wr(3, 32'h2);
    rd(1, 32'h0002_0008, "status_ovf_cleared");

    // pop while full with in_valid held: pop only, dropped keycode flags overflow
    @(negedge clk);
    in_valid = 1'b1; in_keycode = 8'h55;
    chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
    #1 check("full_pop_data", readdata, 32'h8000_0040);
    check("full_pop_ready", in_ready, 0);
    @(negedge clk);
    address = 2'd1;
    #1 check("after_pop_status", readdata, 32'h0004_0007);
    check("after_pop_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; chipselect = 1'b0; read_n = 1'b1;
    rd(1, 32'h0006_0008, "refill_status");
    rd(0, 32'h8000_0041, "refill_head");
    wr(3, 32'h3);
    rd(1, 32'h0001_0000, "flush_status");

    wr(2, 32'h1);
    rd(2, 32'h1, "control");
    check("irq_idle", irq, 0);
    push(8'h1D);
    check("irq_rise", irq, 1);
    rd(0, 32'h8000_001D, "irq_pop");
    check("irq_fall", irq, 0);

    push(8'h01); push(8'h02); push(8'h03);
    @(negedge clk);
    in_valid = 1'b1; in_keycode = 8'h44;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h1;
    @(posedge clk); #1;
    in_valid = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    rd(1, 32'h0001_0000, "flush_push_status");
    rd(0, 32'h0, "flush_push_data");
    check("flush_irq", irq, 0);

    for (int i = 0; i < 8; i++) push(8'(i));
    @(negedge clk);
    in_valid = 1'b1; in_keycode = 8'h99;
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h2;
    @(posedge clk); #1;
    in_valid = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    rd(1, 32'h0006_0008, "clr_vs_set_ovf");

    wr(3, 32'h1);
    check("ovf_irq", irq, 1);
    wr(3, 32'h2);
    check("irq_clear", irq, 0);

    push(8'hAA); push(8'hBB);
    @(negedge clk);
    reset_n = 1'b0;
    #1 check("async_rst_irq", irq, 0);
    address = 2'd1;
    #1 check("async_rst_status", readdata, 32'h0001_0000);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2, 32'h0, "rst_control");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
